io_bank_filter: RTL and testbench
=================================

# io_bank_filter

Parametrised I/O bank front-end between the pin IOBUF arrays (PMOD, Arduino shield, push-buttons) and the processing system.

- **Inbound path:** a configurable synchroniser, a per-pin glitch filter with programmable stability length, and per-pin edge detection with sticky interrupt status.
- **Outbound path:** registers data and tri-state enables before they drive the IOBUF I/T pins.
- One instance serves one pin group of any width. This replaces the direct, unregistered wiring of pin data to the system block.

## Interface
Parameters:
- NUM_PINS, 20, number of pins in the bank (1..64).
- SYNC_STAGES, 2, synchroniser flops per input pin (2..4).
- FILTER_W, 8, width of the filter length and per-pin stability counters.

Ports:
- clk  in  1  bank clock; every register below is in this domain.
- rst  in  1  reset, asynchronous and active-high.
- pin_i  in  NUM_PINS  raw pin values from IOBUF O.
- pin_o  out  NUM_PINS  registered drive value to IOBUF I.
- pin_t  out  NUM_PINS  registered tri-state to IOBUF T (1 = high-Z).
- data_out  in  NUM_PINS  requested output values from the system.
- tri_in  in  NUM_PINS  requested tri-state from the system (1 = input).
- data_in  out  NUM_PINS  filtered, synchronised pin values.
- filter_len  in  FILTER_W  consecutive stable cycles required to accept a new level; 0 = filter bypass.
- rise_en  in  NUM_PINS  per-pin enable for rising-edge status.
- fall_en  in  NUM_PINS  per-pin enable for falling-edge status.
- irq_clr  in  NUM_PINS  write-1-to-clear pulse for irq_status bits.
- irq_status  out  NUM_PINS  sticky edge-event flags.
- irq  out  1  registered OR of irq_status.

## Operation
- **Reset values:** pin_o = 0; pin_t = all ones, so every pin is high-Z; data_in = 0; irq_status = 0; irq = 0. Synchroniser flops and stability counters are also cleared.
- **Output path:** pin_o <= data_out and pin_t <= tri_in every cycle, with no other logic.
- **Synchroniser:** a SYNC_STAGES-deep flop chain per pin. Its last stage is sync[i].
- **Filter, per pin.** The pin has a counter cnt[i] (FILTER_W bits).
  - filter_len == 0: data_in[i] <= sync[i] every cycle, and cnt[i] is held at 0.
  - sync[i] == data_in[i]: cnt[i] <= 0.
  - sync[i] != data_in[i] and cnt[i] >= filter_len-1: data_in[i] <= sync[i] and cnt[i] <= 0. The >= comparison means a filter_len reduced mid-count takes effect immediately.
  - sync[i] != data_in[i] otherwise: cnt[i] <= cnt[i]+1.
  - Any return to the accepted level before acceptance discards the count. Glitches shorter than filter_len cycles never reach data_in.
  - cnt never wraps, because it is cleared on acceptance and filter_len ≤ 2^FILTER_W-1.
- **Edge events.** An event occurs in the cycle data_in[i] is updated to a new value:
  - 0→1 sets irq_status[i] if rise_en[i].
  - 1→0 sets irq_status[i] if fall_en[i].
- **Status and interrupt.**
  - irq_status[i] holds until irq_clr[i] is high for a cycle.
  - If a set and irq_clr[i] occur in the same cycle, set wins and the bit stays 1.
  - irq <= |irq_status, registered.
- **Post-reset behaviour:** a pin sitting high out of reset is accepted as a rising edge after the normal latency. Software clears it; the block does not suppress it.
- Pins are fully independent. Simultaneous events on any number of pins are all captured.

## Timing
- **Input latency:** a pin_i change sampled at edge k appears on data_in after edge k + SYNC_STAGES + max(filter_len,1) - 1. Counted in edges, that is SYNC_STAGES + max(filter_len,1) edges including edge k.
- **irq_status** sets on the same edge as the data_in update.
- **irq** asserts one edge after irq_status sets. It deasserts one edge after the last status bit clears.
- **irq_clr** takes effect on the edge it is sampled.
- **Output latency:** data_out/tri_in to pin_o/pin_t is 1 cycle.
- **Reset:** assertion mid-operation forces all reset values immediately, without waiting for clk. The first update after deassertion occurs on the first clk edge.

## Test plan
- **Reset:** pin_i = all ones, rst high → pin_t = all ones, pin_o = 0, irq = 0 during reset. With filter_len = 4, SYNC_STAGES = 2, rise_en = all ones, data_in goes all ones after 6 edges, irq_status = all ones, and irq = 1 one edge later.
- **Filter accept:** filter_len = 4, pin 3 rises before edge 0 → data_in[3] = 1 after edge 5 and irq_status[3] = 1 after edge 5. With filter_len = 0 the same stimulus gives data_in[3] = 1 after edge 2.
- **Glitch reject:** filter_len = 4, pin 7 high for 3 cycles then low → data_in[7] stays 0, irq_status[7] stays 0, and cnt returns to 0. A 4-cycle pulse is accepted, then rejected on return if the low level lasts < 4 cycles.
- **Edge enables / clear collision:**
  - rise_en[0] = 0, fall_en[0] = 1: a 0→1→0 sequence sets only on the fall.
  - irq_clr[0] pulsed on the same edge as a new fall: irq_status[0] remains 1.
  - A later clr alone: status goes 0, and irq drops one edge after.
- **Output path and async reset:** tri_in = 0, data_out = 0xA5A5 → pin_t = 0, pin_o = 0xA5A5 one edge later. rst asserted between edges → pin_t = all ones and pin_o = 0 immediately, and data_in clears mid-filter-count.

Source files
------------

// File: rtl/io_bank_filter_if.sv
// io_bank_filter_if: pin-side and system-side signal bundle of one I/O bank
// pin_i/pin_o/pin_t: IOBUF O/I/T; data_out/tri_in: system drive requests; data_in: filtered pins
// filter_len: stability length (0 = bypass); rise_en/fall_en/irq_clr: edge status control
// irq_status/irq: sticky edge flags and their registered OR
interface io_bank_filter_if #(
  parameter int NUM_PINS = 20,
  parameter int FILTER_W = 8
);
  logic [NUM_PINS-1:0] pin_i;
  logic [NUM_PINS-1:0] pin_o;
  logic [NUM_PINS-1:0] pin_t;
  logic [NUM_PINS-1:0] data_out;
  logic [NUM_PINS-1:0] tri_in;
  logic [NUM_PINS-1:0] data_in;
  logic [FILTER_W-1:0] filter_len;
  logic [NUM_PINS-1:0] rise_en;
  logic [NUM_PINS-1:0] fall_en;
  logic [NUM_PINS-1:0] irq_clr;
  logic [NUM_PINS-1:0] irq_status;
  logic irq;
  modport master (
    output pin_i, data_out, tri_in, filter_len, rise_en, fall_en, irq_clr,
    input pin_o, pin_t, data_in, irq_status, irq
  );
  modport slave (
    input pin_i, data_out, tri_in, filter_len, rise_en, fall_en, irq_clr,
    output pin_o, pin_t, data_in, irq_status, irq
  );
endinterface

// File: rtl/io_bank_filter.sv
// io_bank_filter: registered IOBUF drive plus synchronised, glitch-filtered pin inputs with edge interrupts
// clk/rst: bank clock and asynchronous active-high reset
// bus (slave): pin_i/pin_o/pin_t, data_out/tri_in, data_in, filter_len, rise_en/fall_en, irq_clr, irq_status, irq
module io_bank_filter #(
  parameter int NUM_PINS = 20,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W = 8
) (
  input logic clk,
  input logic rst,
  io_bank_filter_if.slave bus
);
  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
  logic [NUM_PINS-1:0][FILTER_W-1:0] cnt;
  logic [NUM_PINS-1:0][FILTER_W-1:0] cnt_d;
  logic [NUM_PINS-1:0] sync;
  logic [NUM_PINS-1:0] diff;
  logic [NUM_PINS-1:0] take;
  logic [NUM_PINS-1:0] set;
  logic [FILTER_W-1:0] len_m1;
  logic bypass;
  assign sync = sync_q[SYNC_STAGES-1];
  assign bypass = bus.filter_len == '0;
  assign len_m1 = bus.filter_len - 1'b1;
  assign diff = sync ^ bus.data_in;
  // >= rather than == so a filter_len lowered mid-count accepts at once
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    assign take[g] = diff[g] & (bypass | (cnt[g] >= len_m1));
    assign cnt_d[g] = (bypass | ~diff[g] | take[g]) ? '0 : cnt[g] + 1'b1;
  end
  assign set = take & ((sync & bus.rise_en) | (~sync & bus.fall_en));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      cnt <= '0;
      bus.data_in <= '0;
      bus.irq_status <= '0;
      bus.irq <= 1'b0;
      bus.pin_o <= '0;
      bus.pin_t <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pin_i};
      cnt <= cnt_d;
      bus.data_in <= bus.data_in ^ take;
      bus.irq_status <= (bus.irq_status & ~bus.irq_clr) | set;
      bus.irq <= |bus.irq_status;
      bus.pin_o <= bus.data_out;
      bus.pin_t <= bus.tri_in;
    end
endmodule

// File: tb/tb_io_bank_filter.sv
// tb_io_bank_filter: scoreboard bench comparing io_bank_filter against a pin-history reference model
module tb_io_bank_filter;
  localparam int N = 20;
  localparam int S = 2;
  localparam int W = 8;
  typedef struct packed {
    logic [N-1:0] din;
    logic [N-1:0] st;
    logic [N-1:0] po;
    logic [N-1:0] pt;
    logic irq;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passed = 0;
  exp_t sb[$];
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_din, m_st, m_po, m_pt;
  logic m_irq;
  io_bank_filter_if #(.NUM_PINS(N), .FILTER_W(W)) bus();
  io_bank_filter #(.NUM_PINS(N), .SYNC_STAGES(S), .FILTER_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction
  function automatic void model_reset();
    m_pipe = {};
    for (int i = 0; i < S; i++) m_pipe.push_back('0);
    m_hist = {};
    m_din = '0;
    m_st = '0;
    m_po = '0;
    m_pt = '1;
    m_irq = 1'b0;
  endfunction
  // A pin accepts a new level once the synchronised value has differed from
  // the accepted level for max(filter_len,1) consecutive edges.
  function automatic void model_edge();
    logic [N-1:0] s, take, set, h;
    int need, run;
    s = m_pipe[S-1];
    m_pipe.push_front(bus.pin_i);
    m_pipe = m_pipe[0:S-1];
    m_hist.push_back(s);
    if (m_hist.size() > 64) h = m_hist.pop_front();
    need = (bus.filter_len == '0) ? 1 : int'(bus.filter_len);
    for (int i = 0; i < N; i++) begin
      run = 0;
      for (int j = m_hist.size() - 1; j >= 0; j--) begin
        h = m_hist[j];
        if (h[i] == m_din[i] || run >= need) break;
        run++;
      end
      take[i] = run >= need;
    end
    set = take & ((s & bus.rise_en) | (~s & bus.fall_en));
    m_irq = |m_st;
    m_st = (m_st & ~bus.irq_clr) | set;
    m_din = m_din ^ take;
    m_po = bus.data_out;
    m_pt = bus.tri_in;
  endfunction
  task automatic tick();
    if (rst) model_reset();
    else model_edge();
    sb.push_back('{m_din, m_st, m_po, m_pt, m_irq});
    @(negedge clk);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("data_in", bus.data_in, e.din);
      chk("irq_status", bus.irq_status, e.st);
      chk("pin_o", bus.pin_o, e.po);
      chk("pin_t", bus.pin_t, e.pt);
      chk("irq", bus.irq, e.irq);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.pin_i = '1;
    bus.data_out = '0;
    bus.tri_in = '1;
    bus.filter_len = 8'd4;
    bus.rise_en = '1;
    bus.fall_en = '0;
    bus.irq_clr = '0;
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("reset pin_t", bus.pin_t, '1);
    chk("reset pin_o", bus.pin_o, '0);
    chk("reset irq", bus.irq, '0);
    chk("reset data_in", bus.data_in, '0);
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    repeat (9) tick();
    bus.irq_clr = '1;
    tick();
    bus.irq_clr = '0;
    bus.pin_i = '0;
    repeat (8) tick();
    bus.pin_i[3] = 1'b1;
    repeat (8) tick();
    bus.filter_len = 8'd0;
    bus.pin_i[3] = 1'b0;
    repeat (4) tick();
    bus.pin_i[3] = 1'b1;
    repeat (4) tick();
    bus.filter_len = 8'd4;
    bus.pin_i[7] = 1'b1;
    repeat (3) tick();
    bus.pin_i[7] = 1'b0;
    repeat (8) tick();
    bus.pin_i[7] = 1'b1;
    repeat (4) tick();
    bus.pin_i[7] = 1'b0;
    repeat (3) tick();
    bus.pin_i[7] = 1'b1;
    repeat (8) tick();
    bus.filter_len = 8'd0;
    bus.rise_en[0] = 1'b0;
    bus.fall_en[0] = 1'b1;
    bus.irq_clr = '1;
    tick();
    bus.irq_clr = '0;
    bus.pin_i[0] = 1'b1;
    repeat (4) tick();
    bus.pin_i[0] = 1'b0;
    tick();
    tick();
    bus.irq_clr[0] = 1'b1;
    tick();
    bus.irq_clr[0] = 1'b0;
    repeat (2) tick();
    bus.irq_clr[0] = 1'b1;
    tick();
    bus.irq_clr[0] = 1'b0;
    repeat (3) tick();
    bus.tri_in = '0;
    bus.data_out = 20'h0A5A5;
    repeat (2) tick();
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] m, k;
      for (int i = 0; i < N; i++) begin
        m[i] = $urandom_range(5) == 0;
        k[i] = $urandom_range(7) == 0;
      end
      bus.pin_i = bus.pin_i ^ m;
      bus.irq_clr = k;
      if (c % 150 == 0) bus.filter_len = W'($urandom_range(5));
      if (c % 100 == 0) begin
        bus.rise_en = N'($urandom);
        bus.fall_en = N'($urandom);
      end
      bus.data_out = N'($urandom);
      bus.tri_in = N'($urandom);
      tick();
    end
    bus.irq_clr = '0;
    bus.rise_en = '1;
    bus.fall_en = '1;
    bus.filter_len = 8'd6;
    bus.data_out = 20'h5A5A5;
    bus.tri_in = 20'h00F0F;
    bus.pin_i = ~bus.pin_i;
    repeat (4) tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async pin_t", bus.pin_t, '1);
    chk("async pin_o", bus.pin_o, '0);
    chk("async data_in", bus.data_in, '0);
    chk("async irq_status", bus.irq_status, '0);
    chk("async irq", bus.irq, '0);
    model_reset();
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    @(posedge clk);
    #2;
    chk("scoreboard drained", N'(sb.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
